// File: rtl/gcd_engine.sv
// gcd_engine: parametrised GCD coprocessor, subtractive or binary (Stein) algorithm chosen per launch.
// Latency: launch edge, then one step per RUN cycle; done pulses for one cycle after the terminal step.
// Backpressure: none; start is ignored while busy, abort drops back to IDLE without a done pulse.
module gcd_engine #(
   parameter int WIDTH  = 16,
   parameter int ITER_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              mode,
   input  logic [WIDTH-1:0]  x,
   input  logic [WIDTH-1:0]  y,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  result,
   output logic              err,
   output logic [ITER_W-1:0] iters
);

   // k counts the common factors of two stripped in binary mode; at most WIDTH-1 of them
   localparam int K_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } gcdState;

   gcdState          state;
   logic [WIDTH-1:0] xr;
   logic [WIDTH-1:0] yr;
   logic [K_W-1:0]   k;
   logic             modeR;
   logic             bothZero;

   logic [WIDTH-1:0] nextXr;
   logic [WIDTH-1:0] nextYr;
   logic [K_W-1:0]   nextK;
   logic             isTerminal;
   logic [WIDTH-1:0] termResult;

   // One algorithm step on the working registers; first matching rule wins
   always_comb begin
      nextXr     = xr;
      nextYr     = yr;
      nextK      = k;
      isTerminal = 1'b0;
      termResult = '0;
      if (!modeR) begin
         // Subtractive: keep XR >= YR by swapping, then subtract
         if (yr == '0) begin
            isTerminal = 1'b1;
            termResult = xr;
         end else if (xr < yr) begin
            nextXr = yr;
            nextYr = xr;
         end else begin
            nextXr = xr - yr;
         end
      end else begin
         // Binary: strip twos, subtract odd from odd and halve the even difference
         if (yr == '0) begin
            isTerminal = 1'b1;
            termResult = xr << k;
         end else if (xr == '0) begin
            isTerminal = 1'b1;
            termResult = yr << k;
         end else if (!xr[0] && !yr[0]) begin
            nextXr = xr >> 1;
            nextYr = yr >> 1;
            nextK  = k + K_W'(1);
         end else if (!xr[0]) begin
            nextXr = xr >> 1;
         end else if (!yr[0]) begin
            nextYr = yr >> 1;
         end else if (xr >= yr) begin
            nextXr = (xr - yr) >> 1;
         end else begin
            nextYr = (yr - xr) >> 1;
         end
      end
   end

   // Control FSM with registered handshake outputs and the working datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         xr       <= '0;
         yr       <= '0;
         k        <= '0;
         modeR    <= 1'b0;
         bothZero <= 1'b0;
         result   <= '0;
         iters    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               // DONE accepts a new start directly so back-to-back launches lose no cycle
               if (start) begin
                  state    <= ST_RUN;
                  xr       <= x;
                  yr       <= y;
                  k        <= '0;
                  modeR    <= mode;
                  bothZero <= (x == '0) && (y == '0);
                  iters    <= '0;
                  err      <= 1'b0;
                  busy     <= 1'b1;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  // Abort wins over the step: result, err and iters keep their values
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  if (!(&iters)) begin
                     iters <= iters + ITER_W'(1);
                  end
                  if (isTerminal) begin
                     state  <= ST_DONE;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     result <= termResult;
                     err    <= bothZero;
                  end else begin
                     xr <= nextXr;
                     yr <= nextYr;
                     k  <= nextK;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/gcd_engine.md
Name: gcd_engine

Overview:
- Parametrised, handshaked GCD coprocessor. It is the successor to the fixed 16-bit subtract/swap GCD datapath.
- Adds a WIDTH parameter, a start/busy/done handshake and a runtime-selectable algorithm: subtractive or binary (Stein).
- Adds abort, a zero-operand error flag and an iteration counter.
- Sits behind a controller or CPU-side register block that launches one operand pair at a time.

Parameters:
- WIDTH, 16, operand and result width in bits (≥2).
- ITER_W, 16, width of the iteration counter; the counter saturates at all-ones.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  launch request; sampled in IDLE or DONE
- abort  in  1  cancel the current computation; honoured in RUN only
- mode  in  1  0 = subtractive, 1 = binary (Stein); latched at start
- x  in  WIDTH  operand X; latched at start
- y  in  WIDTH  operand Y; latched at start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when result is valid
- result  out  WIDTH  GCD; holds its value until the next completion
- err  out  1  set with done when x == y == 0; cleared at the next accepted start
- iters  out  ITER_W  RUN cycles used by the last computation, saturating

Behaviour:
- Reset (rst = 0, asynchronous): state = IDLE; XR, YR, k, result, iters = 0; busy, done, err = 0.
- States and transitions:
  - IDLE → RUN on start = 1.
  - RUN → DONE on a terminal step.
  - RUN → IDLE on abort.
  - DONE → IDLE, or DONE → RUN if start = 1 (back-to-back launch).
- Start edge:
  - XR ← x, YR ← y, latch mode, k ← 0, iters ← 0, err ← 0.
  - busy = 1 from the next cycle.
- Every RUN edge performs exactly one step and increments iters (saturating).
- Subtractive step, first match wins:
  - YR == 0 → terminal, result ← XR.
  - XR < YR → swap XR and YR.
  - otherwise → XR ← XR − YR.
- Binary step, first match wins:
  - YR == 0 → terminal, result ← XR << k.
  - XR == 0 → terminal, result ← YR << k.
  - both even → XR >>= 1, YR >>= 1, k += 1.
  - XR even → XR >>= 1.
  - YR even → YR >>= 1.
  - XR ≥ YR → XR ← (XR − YR) >> 1.
  - otherwise → YR ← (YR − XR) >> 1.
- Width rules:
  - k is clog2(WIDTH)+1 bits.
  - Subtraction is unsigned and only ever computed when minuend ≥ subtrahend.
  - The shift back by k never overflows because gcd ≤ max(x, y).
- Terminal step: state → DONE; err ← (both latched operands were 0).
- DONE lasts one cycle: done = 1, busy = 0.
- abort = 1 in RUN:
  - Next state is IDLE; done is not asserted.
  - result and err are unchanged; iters holds the count so far.
  - abort in IDLE/DONE is ignored; abort takes priority over the current step.
- start while busy is ignored; operand changes during RUN have no effect.
- gcd(0, 0):
  - 1 RUN cycle; result = 0, err = 1, iters = 1.
- gcd(a, 0) or gcd(0, a):
  - Result = a.
  - Iteration counts:
    - Subtractive (0, a): swap, then terminal, iters = 2.
    - Binary (0, a) with a odd: XR == 0 check hits in the first step, iters = 1.
- rst asserted mid-RUN: immediately IDLE with all outputs zeroed; no done.
- Operands at the maximum (2^WIDTH−1) must produce correct results in both modes.

Test Plan:
- Mode 0, x=25, y=15, start pulse → 8 RUN cycles; done pulse with result=5, iters=8, err=0; busy high for exactly 8 cycles.
- Mode 1, x=24, y=36 → sequence (12,18,k1), (6,9,k2), (3,9), (3,3), (0,3); done with result=12, iters=6.
- x=0, y=0 in both modes → done after 1 RUN cycle, result=0, err=1. Next start with x=7, y=0 → result=7, err=0.
- Mode 0, x=65535, y=1, abort raised after 10 RUN cycles → returns to IDLE, no done, result keeps its previous value, iters=10. rst pulse mid-RUN → all outputs 0 at once.
- start held high across DONE with new operands (9, 6), mode 1 → second run starts on the DONE edge with no IDLE gap; result=3. start pulses during RUN are ignored.
- WIDTH=8 instance, random operand pairs in both modes → result matches a reference GCD model. Binary iters ≤ 2·WIDTH+2 for all pairs.
